icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller's instruction port.
- On a hit it returns the instruction without touching memory.
- On a miss it issues one 4-byte fetch to the controller, waits for the reply, fills the line and forwards the word.
- It snoops data-side stores so self-modifying code never executes stale lines.

Parameters:
INDEX_BITS, 7, log2 of line count (128 lines); index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-low reset; rst==0 at posedge resets the block
rdy  in  1  global enable; 0 freezes all state and outputs
clr_i  in  1  pipeline flush; abandons any outstanding fetch
fetchEn_i  in  1  IF requests instruction at fetchAddr_i (level, held until fetchRdy_o)
fetchAddr_i  in  32  fetch address; bits [1:0] ignored
fetchRdy_o  out  1  one-cycle pulse: fetchInst_o valid
fetchInst_o  out  32  instruction word (registered)
memEn_o  out  1  one-cycle request pulse to memory controller
memAddr_o  out  32  word-aligned fetch address {addr[31:2],2'b00}
memBusy_i  in  1  controller cannot accept a new instruction request this cycle
memRdy_i  in  1  one-cycle pulse: memData_i holds requested word
memData_i  in  32  fetched word, little-endian assembled by controller
storeEn_i  in  1  data-side store in progress (snoop)
storeAddr_i  in  32  store address; bits [1:0] ignored

Behaviour:
- Priority at each posedge: rst==0 > clr_i > rdy==0 (hold) > normal operation.
- Reset values:
  - fetchRdy_o=0, fetchInst_o=0, memEn_o=0, memAddr_o=0.
  - state=IDLE, all valid bits=0, stale flag=0.
  - Tag and data arrays are not reset.
- clr_i: state->IDLE, fetchRdy_o=0, memEn_o=0, stale=0. Valid/tag/data arrays untouched. A memRdy_i arriving later while IDLE is ignored; the controller also clears on clr_i.
- Storage: valid[2^INDEX_BITS], tag array, data array (32b). Lookup is combinational on fetchAddr_i; outputs are registered.
- FSM IDLE:
  - fetchEn_i=1 and fetchRdy_o=0 (one-cycle bubble after every response, since IF updates PC at that edge):
    - Hit (valid & tag match): next cycle fetchRdy_o=1, fetchInst_o=data[index]; stay IDLE. Hit latency 1 cycle; throughput 1 per 2 cycles.
    - Miss: latch fetch address into reqAddr; ->REQ.
  - Otherwise fetchRdy_o=0.
- FSM REQ:
  - memBusy_i=0: memEn_o=1 for exactly this one cycle (registered, asserted the cycle after the decision), memAddr_o=reqAddr word-aligned; ->WAIT.
  - memBusy_i=1: memEn_o=0; stay REQ.
  - memAddr_o holds reqAddr until the next request.
- FSM WAIT:
  - memEn_o=0.
  - On memRdy_i: fetchRdy_o=1 and fetchInst_o=memData_i next cycle (bypass, no second lookup). If stale=0, write valid=1, tag, data at reqAddr index. stale->0; ->IDLE.
  - Without memRdy_i: stay WAIT; no timeout.
- Snoop, any state: storeEn_i=1 clears valid[storeAddr_i index] when its tag matches (word granularity). If state is REQ/WAIT and storeAddr_i[31:2]==reqAddr[31:2], set stale=1: the in-flight word is still forwarded to IF but not installed.
- Snoop vs fill to the same line in the same cycle: invalidate wins, the line ends invalid. Fill to a different index proceeds normally.
- fetchEn_i dropping during REQ/WAIT has no effect; the fill completes. fetchRdy_o pulses regardless and IF ignores it.
- rdy=0: every register holds, including a memEn_o pulse already on the output. A memRdy_i pulse while rdy=0 is not observed; the controller is frozen by the same rdy.
- Reset mid-miss: returns to IDLE with the cache empty; no memEn_o issued.

Test Plan:
- Cold miss: reset, fetchEn_i=1, addr 0x00000100, memBusy_i=0, memRdy_i 6 cycles after memEn_o with data 0x00A00093.
  - Expect one memEn_o pulse, memAddr_o=0x100, fetchRdy_o pulse with 0x00A00093.
  - Re-fetch 0x100 -> fetchRdy_o exactly 1 cycle later, no memEn_o.
- Conflict: fill 0x100, then fetch 0x300 (same index, INDEX_BITS=7) -> miss, refill. Fetch 0x100 again -> miss.
- Busy back-pressure: miss with memBusy_i=1 for 5 cycles -> memEn_o stays 0. memEn_o pulses the cycle after memBusy_i falls.
- Flush mid-miss: miss on 0x200, clr_i during WAIT, then memRdy_i pulse -> no fetchRdy_o, line 0x200 remains invalid (next fetch misses).
- Snoop: cached 0x100; storeEn_i, storeAddr_i=0x102 -> next fetch 0x100 misses.
  - Store to 0x104 during an in-flight miss of 0x104 -> word forwarded, next fetch 0x104 misses again.
- Freeze: rdy=0 for 3 cycles during WAIT with memRdy_i low -> all outputs constant; operation resumes unchanged.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetch-side, memory-side and store-snoop signals of the direct-mapped instruction cache.
// slave is the cache; master is whoever drives IF, the memory controller and the snoop.
interface icache_direct_if;
    logic        fetchEn_i;
    logic [31:0] fetchAddr_i;
    logic        fetchRdy_o;
    logic [31:0] fetchInst_o;
    logic        memEn_o;
    logic [31:0] memAddr_o;
    logic        memBusy_i;
    logic        memRdy_i;
    logic [31:0] memData_i;
    logic        storeEn_i;
    logic [31:0] storeAddr_i;

    modport slave (
        input  fetchEn_i, fetchAddr_i, memBusy_i, memRdy_i, memData_i, storeEn_i, storeAddr_i,
        output fetchRdy_o, fetchInst_o, memEn_o, memAddr_o
    );
    modport master (
        output fetchEn_i, fetchAddr_i, memBusy_i, memRdy_i, memData_i, storeEn_i, storeAddr_i,
        input  fetchRdy_o, fetchInst_o, memEn_o, memAddr_o
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with store snooping.
// Hits answer one cycle after the request; misses go through a single memory fetch.
module icache_direct #(
    parameter int INDEX_BITS = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            clr_i,
    icache_direct_if.slave  bus
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [31:0]           r_data [LINES];
    logic [29:0]           r_req_word;
    logic                  r_stale;
    logic                  r_fetch_rdy;
    logic [31:0]           r_fetch_inst;
    logic                  r_mem_en;
    logic [31:0]           r_mem_addr;

    logic [INDEX_BITS-1:0] w_f_idx, w_s_idx, w_r_idx;
    logic [TAG_W-1:0]      w_f_tag, w_s_tag, w_r_tag;
    logic                  w_hit, w_s_hit, w_s_req, w_fill, w_install;
    logic                  w_unused;

    assign w_f_idx = bus.fetchAddr_i[INDEX_BITS+1:2];
    assign w_f_tag = bus.fetchAddr_i[31:INDEX_BITS+2];
    assign w_s_idx = bus.storeAddr_i[INDEX_BITS+1:2];
    assign w_s_tag = bus.storeAddr_i[31:INDEX_BITS+2];
    assign w_r_idx = r_req_word[INDEX_BITS-1:0];
    assign w_r_tag = r_req_word[29:INDEX_BITS];

    assign w_hit   = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_s_hit = bus.storeEn_i && r_valid[w_s_idx] && (r_tag[w_s_idx] == w_s_tag);
    assign w_s_req = bus.storeEn_i && (bus.storeAddr_i[31:2] == r_req_word);
    assign w_fill  = (r_state == S_WAIT) && bus.memRdy_i;
    // A store landing on the fill's index in the fill cycle blocks the install: invalidate wins.
    assign w_install = w_fill && !r_stale && !(bus.storeEn_i && (w_s_idx == w_r_idx));

    assign w_unused = ^{bus.fetchAddr_i[1:0], bus.storeAddr_i[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_stale      <= 1'b0;
            r_req_word   <= '0;
            r_fetch_rdy  <= 1'b0;
            r_fetch_inst <= '0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
        end else if (clr_i) begin
            r_state     <= S_IDLE;
            r_fetch_rdy <= 1'b0;
            r_mem_en    <= 1'b0;
            r_stale     <= 1'b0;
        end else if (rdy) begin
            r_fetch_rdy <= 1'b0;
            r_mem_en    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The !r_fetch_rdy term leaves a bubble while IF advances its PC.
                    if (bus.fetchEn_i && !r_fetch_rdy) begin
                        if (w_hit) begin
                            r_fetch_rdy  <= 1'b1;
                            r_fetch_inst <= r_data[w_f_idx];
                        end else begin
                            r_req_word <= bus.fetchAddr_i[31:2];
                            r_state    <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (!bus.memBusy_i) begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= {r_req_word, 2'b00};
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.memRdy_i) begin
                        r_fetch_rdy  <= 1'b1;
                        r_fetch_inst <= bus.memData_i;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_install) r_valid[w_r_idx] <= 1'b1;
            if (w_s_hit)   r_valid[w_s_idx] <= 1'b0;

            if (w_fill)
                r_stale <= 1'b0;
            else if ((r_state != S_IDLE) && w_s_req)
                r_stale <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (rst && !clr_i && rdy && w_install) begin
            r_tag[w_r_idx]  <= w_r_tag;
            r_data[w_r_idx] <= bus.memData_i;
        end
    end

    assign bus.fetchRdy_o  = r_fetch_rdy;
    assign bus.fetchInst_o = r_fetch_inst;
    assign bus.memEn_o     = r_mem_en;
    assign bus.memAddr_o   = r_mem_addr;
endmodule

// File: tb/tb_icache_direct.sv
// Randomized and directed bench for icache_direct against a line-level reference model.
module tb_icache_direct;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic clr_i = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    icache_direct_if bus ();

    icache_direct #(.INDEX_BITS(7)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .clr_i (clr_i),
        .bus   (bus)
    );

    // Reference model: one entry per line index, 128 lines, 23-bit tags.
    bit          m_valid [128];
    logic [22:0] m_tag   [128];
    logic [31:0] m_data  [128];

    function automatic int ix(input logic [31:0] a);
        return int'(a[8:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[ix(a)] && (m_tag[ix(a)] == a[31:9]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    endtask

    // Snoop first (against the line as it stood), then install unless the store hit
    // the same word earlier or the same index in the fill cycle.
    task automatic model_apply(input logic [31:0] a, input logic [31:0] d, input bit was_hit,
                               input bit st_done, input bit st_fill, input logic [31:0] sa);
        bit inst_ok;
        if (st_done && model_hit(sa)) m_valid[ix(sa)] = 1'b0;
        if (!was_hit) begin
            inst_ok = !(st_done && ((sa[31:2] == a[31:2]) || (st_fill && ix(sa) == ix(a))));
            if (inst_ok) begin
                m_valid[ix(a)] = 1'b1;
                m_tag[ix(a)]   = a[31:9];
                m_data[ix(a)]  = d;
            end
        end
    endtask

    // Drives one fetch and acts as the memory controller; only reports observations.
    task automatic fetch_txn(input logic [31:0] addr, input int busy, input int lat,
                             input logic [31:0] data, input int st_cyc, input logic [31:0] st_addr,
                             output int lat_obs, output int en_cyc, output int npulse,
                             output logic [31:0] maddr, output logic [31:0] inst,
                             output bit st_done, output bit st_fill);
        int cyc = 0;
        int wait_c = -1;
        bit done = 0;
        lat_obs = -1; en_cyc = -1; npulse = 0; maddr = '0; inst = '0;
        st_done = 0; st_fill = 0;
        bus.fetchEn_i = 1'b1;
        bus.fetchAddr_i = addr;
        bus.memBusy_i = (busy > 0);
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
            bus.storeEn_i = 1'b0;
            bus.memRdy_i = 1'b0;
            if (bus.fetchRdy_o) begin
                lat_obs = cyc;
                inst = bus.fetchInst_o;
                done = 1;
            end
            if (bus.memEn_o) begin
                npulse++;
                maddr = bus.memAddr_o;
                if (en_cyc < 0) begin
                    en_cyc = cyc;
                    wait_c = lat;
                end
            end else if (wait_c > 0) begin
                wait_c--;
                if (wait_c == 0) begin
                    bus.memRdy_i = 1'b1;
                    bus.memData_i = data;
                end
            end
            if (cyc >= busy) bus.memBusy_i = 1'b0;
            if (!done && cyc == st_cyc) begin
                bus.storeEn_i = 1'b1;
                bus.storeAddr_i = st_addr;
                st_done = 1;
                st_fill = bus.memRdy_i;
            end
        end
        bus.fetchEn_i = 1'b0;
        bus.memRdy_i = 1'b0;
        bus.storeEn_i = 1'b0;
        bus.memBusy_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.fetchRdy_o !== 1'b0) begin errors++; $display("FAIL reset_fetchRdy got %0b exp 0", bus.fetchRdy_o); end
        checks++; if (bus.fetchInst_o !== 32'h0) begin errors++; $display("FAIL reset_fetchInst got %h exp 0", bus.fetchInst_o); end
        checks++; if (bus.memEn_o !== 1'b0) begin errors++; $display("FAIL reset_memEn got %0b exp 0", bus.memEn_o); end
        checks++; if (bus.memAddr_o !== 32'h0) begin errors++; $display("FAIL reset_memAddr got %h exp 0", bus.memAddr_o); end
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        int l, e, n; logic [31:0] ma, in; bit sd, sf;
        fetch_txn(32'h100, 0, 6, 32'h00A00093, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL cold_npulse got %0d exp 1", n); end
        checks++; if (ma !== 32'h100) begin errors++; $display("FAIL cold_memAddr got %h exp 100", ma); end
        checks++; if (e !== 2) begin errors++; $display("FAIL cold_en_cycle got %0d exp 2", e); end
        checks++; if (l !== 9) begin errors++; $display("FAIL cold_latency got %0d exp 9", l); end
        checks++; if (in !== 32'h00A00093) begin errors++; $display("FAIL cold_inst got %h exp 00a00093", in); end
        model_apply(32'h100, 32'h00A00093, 0, sd, sf, 32'h0);
        fetch_txn(32'h100, 0, 6, 32'hDEAD0000, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (l !== 1) begin errors++; $display("FAIL hit_latency got %0d exp 1", l); end
        checks++; if (n !== 0) begin errors++; $display("FAIL hit_npulse got %0d exp 0", n); end
        checks++; if (in !== 32'h00A00093) begin errors++; $display("FAIL hit_inst got %h exp 00a00093", in); end
    endtask

    task automatic test_conflict();
        int l, e, n; logic [31:0] ma, in, d; bit sd, sf;
        d = $urandom;
        fetch_txn(32'h300, 0, 3, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL conflict_300_npulse got %0d exp 1", n); end
        checks++; if (in !== d) begin errors++; $display("FAIL conflict_300_inst got %h exp %h", in, d); end
        model_apply(32'h300, d, 0, sd, sf, 32'h0);
        d = 32'h00A00093;
        fetch_txn(32'h100, 0, 2, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL conflict_100_npulse got %0d exp 1", n); end
        checks++; if (in !== d) begin errors++; $display("FAIL conflict_100_inst got %h exp %h", in, d); end
        model_apply(32'h100, d, 0, sd, sf, 32'h0);
    endtask

    task automatic test_busy();
        int l, e, n; logic [31:0] ma, in, d; bit sd, sf;
        d = $urandom;
        fetch_txn(32'h180, 5, 2, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (e !== 6) begin errors++; $display("FAIL busy_en_cycle got %0d exp 6", e); end
        checks++; if (n !== 1) begin errors++; $display("FAIL busy_npulse got %0d exp 1", n); end
        checks++; if (l !== 9) begin errors++; $display("FAIL busy_latency got %0d exp 9", l); end
        checks++; if (in !== d) begin errors++; $display("FAIL busy_inst got %h exp %h", in, d); end
        model_apply(32'h180, d, 0, sd, sf, 32'h0);
    endtask

    task automatic test_back_to_back();
        bit exp_rdy;
        bus.fetchEn_i = 1'b1;
        bus.fetchAddr_i = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_rdy = (i % 2 == 0);
            checks++; if (bus.fetchRdy_o !== exp_rdy) begin errors++; $display("FAIL b2b_rdy[%0d] got %0b exp %0b", i, bus.fetchRdy_o, exp_rdy); end
            checks++; if (bus.fetchInst_o !== m_data[ix(32'h100)]) begin errors++; $display("FAIL b2b_inst[%0d] got %h exp %h", i, bus.fetchInst_o, m_data[ix(32'h100)]); end
        end
        bus.fetchEn_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int l, e, n, seen; logic [31:0] ma, in, d; bit sd, sf;
        bus.fetchEn_i = 1'b1;
        bus.fetchAddr_i = 32'h200;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.memEn_o) seen = 1;
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL flush_memEn_seen got %0d exp 1", seen); end
        bus.fetchEn_i = 1'b0;
        clr_i = 1'b1;
        @(posedge clk); #1;
        clr_i = 1'b0;
        checks++; if (bus.memEn_o !== 1'b0) begin errors++; $display("FAIL flush_memEn got %0b exp 0", bus.memEn_o); end
        bus.memRdy_i = 1'b1;
        bus.memData_i = 32'hBADC0DE0;
        @(posedge clk); #1;
        bus.memRdy_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.fetchRdy_o) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_fetchRdy got %0d pulses exp 0", seen); end
        d = $urandom;
        fetch_txn(32'h200, 0, 2, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL flush_refetch_npulse got %0d exp 1", n); end
        checks++; if (in !== d) begin errors++; $display("FAIL flush_refetch_inst got %h exp %h", in, d); end
        model_apply(32'h200, d, 0, sd, sf, 32'h0);
    endtask

    task automatic test_snoop();
        int l, e, n; logic [31:0] ma, in, d; bit sd, sf;
        bus.storeEn_i = 1'b1;
        bus.storeAddr_i = 32'h102;
        @(posedge clk); #1;
        bus.storeEn_i = 1'b0;
        model_apply(32'h0, 32'h0, 1, 1, 0, 32'h102);
        d = $urandom;
        fetch_txn(32'h100, 0, 2, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL snoop_refetch_npulse got %0d exp 1", n); end
        model_apply(32'h100, d, 0, sd, sf, 32'h0);
        d = $urandom;
        fetch_txn(32'h104, 0, 4, d, 3, 32'h104, l, e, n, ma, in, sd, sf);
        checks++; if (in !== d) begin errors++; $display("FAIL snoop_inflight_inst got %h exp %h", in, d); end
        checks++; if (sd !== 1'b1) begin errors++; $display("FAIL snoop_inflight_store got %0b exp 1", sd); end
        model_apply(32'h104, d, 0, sd, sf, 32'h104);
        d = $urandom;
        fetch_txn(32'h104, 0, 2, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL snoop_stale_npulse got %0d exp 1", n); end
        checks++; if (in !== d) begin errors++; $display("FAIL snoop_stale_inst got %h exp %h", in, d); end
        model_apply(32'h104, d, 0, sd, sf, 32'h0);
    endtask

    task automatic test_freeze();
        int seen; logic [31:0] d, c_inst, c_addr; logic c_rdy;
        d = $urandom;
        bus.fetchEn_i = 1'b1;
        bus.fetchAddr_i = 32'h2A0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(posedge clk); #1;
            if (bus.memEn_o) seen = 1;
        end
        checks++; if (seen !== 1) begin errors++; $display("FAIL freeze_memEn_seen got %0d exp 1", seen); end
        rdy = 1'b0;
        c_rdy = bus.fetchRdy_o; c_inst = bus.fetchInst_o; c_addr = bus.memAddr_o;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (bus.memEn_o !== 1'b1) begin errors++; $display("FAIL freeze_memEn[%0d] got %0b exp 1", i, bus.memEn_o); end
            checks++; if (bus.memAddr_o !== c_addr || bus.fetchRdy_o !== c_rdy || bus.fetchInst_o !== c_inst)
                begin errors++; $display("FAIL freeze_hold[%0d] got %h/%0b/%h exp %h/%0b/%h", i, bus.memAddr_o, bus.fetchRdy_o, bus.fetchInst_o, c_addr, c_rdy, c_inst); end
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.memEn_o !== 1'b0) begin errors++; $display("FAIL freeze_resume_memEn got %0b exp 0", bus.memEn_o); end
        bus.memRdy_i = 1'b1;
        bus.memData_i = d;
        @(posedge clk); #1;
        bus.memRdy_i = 1'b0;
        bus.fetchEn_i = 1'b0;
        checks++; if (bus.fetchRdy_o !== 1'b1 || bus.fetchInst_o !== d) begin errors++; $display("FAIL freeze_resume_resp got %0b/%h exp 1/%h", bus.fetchRdy_o, bus.fetchInst_o, d); end
        @(posedge clk); #1;
        model_apply(32'h2A0, d, 0, 0, 0, 32'h0);
    endtask

    task automatic test_reset_mid_miss();
        int l, e, n, seen; logic [31:0] ma, in, d; bit sd, sf;
        bus.fetchEn_i = 1'b1;
        bus.fetchAddr_i = 32'h3F0;
        bus.memBusy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.fetchEn_i = 1'b0;
        bus.memBusy_i = 1'b0;
        model_reset();
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.memEn_o || bus.fetchRdy_o) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rstmiss_activity got %0d exp 0", seen); end
        d = $urandom;
        fetch_txn(32'h2A0, 0, 2, d, -1, 32'h0, l, e, n, ma, in, sd, sf);
        checks++; if (n !== 1) begin errors++; $display("FAIL rstmiss_empty_npulse got %0d exp 1", n); end
        model_apply(32'h2A0, d, 0, sd, sf, 32'h0);
    endtask

    task automatic test_random();
        int l, e, n, busy, lat, stc, exp_lat; logic [31:0] a, sa, ma, in, d; bit sd, sf, h;
        for (int t = 0; t < 80; t++) begin
            a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            sa = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            busy = $urandom_range(0, 3);
            lat = $urandom_range(1, 4);
            stc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : -1;
            d = $urandom;
            h = model_hit(a);
            fetch_txn(a, busy, lat, d, stc, sa, l, e, n, ma, in, sd, sf);
            if (h) begin
                checks++; if (l !== 1 || n !== 0 || in !== m_data[ix(a)])
                    begin errors++; $display("FAIL rand_hit[%0d] a=%h got lat %0d pulses %0d inst %h exp 1/0/%h", t, a, l, n, in, m_data[ix(a)]); end
            end else begin
                exp_lat = ((busy + 1 > 2) ? busy + 1 : 2) + lat + 1;
                checks++; if (l !== exp_lat || n !== 1 || in !== d || ma !== {a[31:2], 2'b00})
                    begin errors++; $display("FAIL rand_miss[%0d] a=%h got lat %0d pulses %0d inst %h maddr %h exp %0d/1/%h/%h", t, a, l, n, in, ma, exp_lat, d, {a[31:2], 2'b00}); end
            end
            model_apply(a, d, h, sd, sf, sa);
        end
    endtask

    initial begin
        bus.fetchEn_i = 1'b0; bus.fetchAddr_i = '0; bus.memBusy_i = 1'b0;
        bus.memRdy_i = 1'b0; bus.memData_i = '0; bus.storeEn_i = 1'b0; bus.storeAddr_i = '0;
        test_reset();
        test_cold_miss();
        test_conflict();
        test_busy();
        test_back_to_back();
        test_flush();
        test_snoop();
        test_freeze();
        test_reset_mid_miss();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
